// File: rtl/timing_check_monitor.sv
// -----------------------------------------------------------------------------
// timing_check_monitor
//
// Cycle-based setup/hold monitor for NUM_CH data channels against a single
// reference signal. It works like a simulator timing check, but is
// synthesizable and measures in clk cycles.
//
// Each input is compared against a registered copy of itself to detect
// events.
// - A setup violation is raised when a reference event arrives fewer than
//   SETUP_CYC cycles after a data event on a channel. This includes a data
//   event in the same cycle as the reference event.
// - A hold violation is raised when a data event lands inside the HOLD_CYC
//   window that opens after a reference event.
// - Violations are reported as registered one-cycle pulses. Each pulse is
//   counted into a saturating total, and a notifier toggles once per cycle
//   in which any violation fires.
//
// Parameters
//   NUM_CH    : number of data channels (1..32)
//   SETUP_CYC : minimum data-to-reference spacing in cycles, 0 disables
//   HOLD_CYC  : hold window length after a reference event, 0 disables
//   CNT_W     : width of the spacing/hold counters and the violation count
//   DATA_EDGE : 0 any change, 1 rising, 2 falling
//   REF_EDGE  : 0 rising, 1 falling
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst_n        : asynchronous active-low reset
//   enable_i     : checking enabled when high
//   clear_i      : synchronous clear of the count, the notifier and the
//                  since-data counters
//   ref_i        : reference signal, synchronous to clk
//   data_i       : data signals, synchronous to clk
//   setup_viol_o : per-channel one-cycle setup violation pulse
//   hold_viol_o  : per-channel one-cycle hold violation pulse
//   notifier_o   : toggles once per cycle with any violation
//   viol_cnt_o   : saturating total violation count
// -----------------------------------------------------------------------------
module timing_check_monitor #(
  parameter int NUM_CH    = 4,
  parameter int SETUP_CYC = 3,
  parameter int HOLD_CYC  = 2,
  parameter int CNT_W     = 8,
  parameter int DATA_EDGE = 0,
  parameter int REF_EDGE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic              ref_i,
  input  logic [NUM_CH-1:0] data_i,
  output logic [NUM_CH-1:0] setup_viol_o,
  output logic [NUM_CH-1:0] hold_viol_o,
  output logic              notifier_o,
  output logic [CNT_W-1:0]  viol_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W:0]   SETUP_LIM = (CNT_W+1)'(SETUP_CYC);
  localparam int               SUM_W     = CNT_W + 8;

  // Input history used for event detection.
  logic              ref_q;
  logic [NUM_CH-1:0] data_q;
  logic              ref_evt;
  logic [NUM_CH-1:0] data_evt;

  // Per-channel cycles since the last data event, plus the shared hold window.
  logic [CNT_W-1:0]  since_q [NUM_CH];
  logic [CNT_W-1:0]  since_d [NUM_CH];
  logic [CNT_W-1:0]  hold_q, hold_d;

  logic [NUM_CH-1:0] setup_viol_q, setup_viol_d;
  logic [NUM_CH-1:0] hold_viol_q, hold_viol_d;
  logic              notifier_q, notifier_d;
  logic [CNT_W-1:0]  viol_cnt_q, viol_cnt_d;

  logic [7:0]        viol_pop;
  logic [SUM_W-1:0]  viol_sum;

  // Event qualification against the registered copy of each input.
  always_comb begin
    case (DATA_EDGE)
      1:       data_evt = data_i & ~data_q;
      2:       data_evt = ~data_i & data_q;
      default: data_evt = data_i ^ data_q;
    endcase
    ref_evt = (REF_EDGE == 1) ? (~ref_i & ref_q) : (ref_i & ~ref_q);
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    hold_d       = hold_q;
    setup_viol_d = '0;
    hold_viol_d  = '0;
    viol_pop     = '0;

    // The hold window reloads on every reference event, including one that
    // arrives while the window is still open. While disabled it stays closed.
    if (!enable_i) begin
      hold_d = '0;
    end else if (ref_evt && (HOLD_CYC > 0)) begin
      hold_d = HOLD_LD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (clear_i) begin
        since_d[i] = CNT_MAX;
      end else if (data_evt[i]) begin
        since_d[i] = '0;
      end else if (since_q[i] == CNT_MAX) begin
        since_d[i] = CNT_MAX;
      end else begin
        since_d[i] = since_q[i] + 1'b1;
      end

      if (enable_i) begin
        // The counter is 0 in the cycle after the data event, so the
        // data-to-reference spacing is since_q + 1. A same-cycle data event
        // is spacing 0.
        if ((SETUP_CYC > 0) && ref_evt &&
            (data_evt[i] || (({1'b0, since_q[i]} + (CNT_W+1)'(1)) < SETUP_LIM))) begin
          setup_viol_d[i] = 1'b1;
        end
        // A data event that coincides with a reference event is a setup
        // matter only.
        if ((HOLD_CYC > 0) && data_evt[i] && !ref_evt && (hold_q != '0)) begin
          hold_viol_d[i] = 1'b1;
        end
      end

      viol_pop = viol_pop + 8'(setup_viol_d[i]) + 8'(hold_viol_d[i]);
    end

    // The count and the notifier follow the pulses being registered this
    // cycle, so both move in the same cycle the pulse appears. Clear wins
    // over a same-cycle violation.
    viol_sum = SUM_W'(viol_cnt_q) + SUM_W'(viol_pop);
    if (clear_i) begin
      viol_cnt_d = '0;
      notifier_d = 1'b0;
    end else begin
      viol_cnt_d = (viol_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : viol_sum[CNT_W-1:0];
      notifier_d = ((setup_viol_d != '0) || (hold_viol_d != '0)) ? ~notifier_q : notifier_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q        <= 1'b0;
      data_q       <= '0;
      hold_q       <= '0;
      setup_viol_q <= '0;
      hold_viol_q  <= '0;
      notifier_q   <= 1'b0;
      viol_cnt_q   <= '0;
      // NOTE: this small counter array is reset explicitly. Its saturated
      // start value means "no recent data event", which must hold before
      // the first reference event.
      for (int i = 0; i < NUM_CH; i++) begin
        since_q[i] <= CNT_MAX;
      end
    end else begin
      ref_q        <= ref_i;
      data_q       <= data_i;
      hold_q       <= hold_d;
      setup_viol_q <= setup_viol_d;
      hold_viol_q  <= hold_viol_d;
      notifier_q   <= notifier_d;
      viol_cnt_q   <= viol_cnt_d;
      for (int i = 0; i < NUM_CH; i++) begin
        since_q[i] <= since_d[i];
      end
    end
  end

  assign setup_viol_o = setup_viol_q;
  assign hold_viol_o  = hold_viol_q;
  assign notifier_o   = notifier_q;
  assign viol_cnt_o   = viol_cnt_q;

endmodule

// File: tb/tb_timing_check_monitor.sv
// -----------------------------------------------------------------------------
// tb_timing_check_monitor
//
// Directed bench for timing_check_monitor with default parameters
// (4 channels, SETUP_CYC=3, HOLD_CYC=2, CNT_W=8).
//
// Each vector is applied just after a rising edge and is sampled at the next
// edge. The outputs are read 1 ns after that edge, where they show the
// registered result of the vector.
// -----------------------------------------------------------------------------
module tb_timing_check_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_i;
  logic       clear_i;
  logic       ref_i;
  logic [3:0] data_i;
  logic [3:0] setup_viol_o;
  logic [3:0] hold_viol_o;
  logic       notifier_o;
  logic [7:0] viol_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       en;
    logic       clr;
    logic       ref_v;
    logic [3:0] data;
    logic [3:0] exp_setup;
    logic [3:0] exp_hold;
    logic [7:0] exp_cnt;
    logic       exp_notif;
  } vec_t;

  vec_t vq[$];

  timing_check_monitor #(
    .NUM_CH(4), .SETUP_CYC(3), .HOLD_CYC(2), .CNT_W(8), .DATA_EDGE(0), .REF_EDGE(0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .clear_i      (clear_i),
    .ref_i        (ref_i),
    .data_i       (data_i),
    .setup_viol_o (setup_viol_o),
    .hold_viol_o  (hold_viol_o),
    .notifier_o   (notifier_o),
    .viol_cnt_o   (viol_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual timeout, required finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] s, input logic [3:0] h,
                           input logic [7:0] c, input logic n);
    check({tag, " setup"}, int'(setup_viol_o), int'(s));
    check({tag, " hold"},  int'(hold_viol_o),  int'(h));
    check({tag, " cnt"},   int'(viol_cnt_o),   int'(c));
    check({tag, " notif"}, int'(notifier_o),   int'(n));
  endtask

  task automatic add(input logic en, input logic clr, input logic r, input logic [3:0] d,
                     input logic [3:0] s, input logic [3:0] h, input logic [7:0] c,
                     input logic n);
    vec_t v;
    v.en = en; v.clr = clr; v.ref_v = r; v.data = d;
    v.exp_setup = s; v.exp_hold = h; v.exp_cnt = c; v.exp_notif = n;
    vq.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; enable_i = 1'b1; clear_i = 1'b0; ref_i = 1'b0; data_i = 4'h0;

    //   en    clr   ref   data     setup    hold     cnt  notif
    add(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 8'd0,  1'b0); // v0  idle
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 8'd0,  1'b0); // v1  d0 toggles
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 8'd0,  1'b0); // v2
    add(1'b1, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 8'd1,  1'b1); // v3  ref, spacing 2
    add(1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 8'd1,  1'b1); // v4
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 8'd1,  1'b1); // v5
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 8'd1,  1'b1); // v6
    add(1'b1, 1'b0, 1'b0, 4'b0011, 4'b0000, 4'b0000, 8'd1,  1'b1); // v7  d1 toggles
    add(1'b1, 1'b0, 1'b0, 4'b0011, 4'b0000, 4'b0000, 8'd1,  1'b1); // v8
    add(1'b1, 1'b0, 1'b0, 4'b0011, 4'b0000, 4'b0000, 8'd1,  1'b1); // v9
    add(1'b1, 1'b0, 1'b1, 4'b0011, 4'b0000, 4'b0000, 8'd1,  1'b1); // v10 ref, spacing 3
    add(1'b1, 1'b0, 1'b1, 4'b0011, 4'b0000, 4'b0000, 8'd1,  1'b1); // v11
    add(1'b1, 1'b0, 1'b1, 4'b0111, 4'b0000, 4'b0100, 8'd2,  1'b0); // v12 d2 in hold window
    add(1'b1, 1'b0, 1'b1, 4'b0011, 4'b0000, 4'b0000, 8'd2,  1'b0); // v13 window closed
    add(1'b1, 1'b0, 1'b0, 4'b0011, 4'b0000, 4'b0000, 8'd2,  1'b0); // v14
    add(1'b1, 1'b0, 1'b0, 4'b0011, 4'b0000, 4'b0000, 8'd2,  1'b0); // v15
    add(1'b1, 1'b0, 1'b1, 4'b1100, 4'b1111, 4'b0000, 8'd6,  1'b1); // v16 all with ref
    add(1'b1, 1'b0, 1'b0, 4'b1100, 4'b0000, 4'b0000, 8'd6,  1'b1); // v17
    add(1'b1, 1'b0, 1'b1, 4'b1101, 4'b1111, 4'b0000, 8'd10, 1'b0); // v18 ref reload, same-cycle d0
    add(1'b1, 1'b0, 1'b1, 4'b1101, 4'b0000, 4'b0000, 8'd10, 1'b0); // v19
    add(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0010, 8'd11, 1'b1); // v20 hold only due to reload
    add(1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 8'd11, 1'b1); // v21
    add(1'b0, 1'b0, 1'b0, 4'b1110, 4'b0000, 4'b0000, 8'd11, 1'b1); // v22 disabled, d0 toggles
    add(1'b0, 1'b0, 1'b1, 4'b1110, 4'b0000, 4'b0000, 8'd11, 1'b1); // v23 ref, no setup
    add(1'b0, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 8'd11, 1'b1); // v24 no hold
    add(1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 8'd11, 1'b1); // v25 re-enabled
    add(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0000, 8'd12, 1'b0); // v26 counters kept running
    add(1'b1, 1'b1, 1'b1, 4'b1110, 4'b0000, 4'b0001, 8'd0,  1'b0); // v27 clear beats count
    add(1'b1, 1'b0, 1'b0, 4'b1110, 4'b0000, 4'b0000, 8'd0,  1'b0); // v28
    add(1'b1, 1'b0, 1'b1, 4'b1110, 4'b0000, 4'b0000, 8'd0,  1'b0); // v29 clear saturated d0
    add(1'b1, 1'b0, 1'b0, 4'b1110, 4'b0000, 4'b0000, 8'd0,  1'b0); // v30

    // Reset state
    #12;
    check_all("reset", 4'b0000, 4'b0000, 8'd0, 1'b0);
    tick();
    rst_n = 1'b1;

    foreach (vq[k]) begin
      enable_i = vq[k].en; clear_i = vq[k].clr; ref_i = vq[k].ref_v; data_i = vq[k].data;
      tick();
      check_all($sformatf("v%0d", k), vq[k].exp_setup, vq[k].exp_hold,
                vq[k].exp_cnt, vq[k].exp_notif);
    end

    // Saturation: 75 reference rises with all four channels toggling give
    // 300 setup violations.
    for (int k = 1; k <= 75; k++) begin
      ref_i = 1'b1; data_i = ~data_i;
      tick();
      if (k == 63) check("sat 252", int'(viol_cnt_o), 252);
      if (k == 64) check("sat 255", int'(viol_cnt_o), 255);
      ref_i = 1'b0;
      tick();
    end
    check("sat final cnt", int'(viol_cnt_o), 255);
    check("sat notif", int'(notifier_o), 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clear cnt", int'(viol_cnt_o), 0);
    check("clear notif", int'(notifier_o), 0);
    tick();
    check("post clear cnt", int'(viol_cnt_o), 0);

    // Reset in the middle of a hold window aborts it.
    ref_i = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check_all("mid rst", 4'b0000, 4'b0000, 8'd0, 1'b0);
    ref_i = 1'b0; data_i = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
    data_i = 4'b0001;
    tick();
    check_all("post rst d0", 4'b0000, 4'b0000, 8'd0, 1'b0);
    data_i = 4'b0011;
    tick();
    check_all("post rst d1", 4'b0000, 4'b0000, 8'd0, 1'b0);

    // A high reference at the first sample after reset is a rising event.
    rst_n = 1'b0; ref_i = 1'b1; data_i = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();
    check_all("first rise", 4'b0000, 4'b0000, 8'd0, 1'b0);
    data_i = 4'b1000;
    tick();
    check_all("first rise hold", 4'b0000, 4'b1000, 8'd1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
